// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Rounded clock divider producing OS ticks per bit.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator; restart realigns the tick phase to a start edge.
module uart_os_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OS       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic os_tick
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OS);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    os_tick = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      os_tick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 oversampling UART receiver with mid-bit majority vote, false-start
// rejection and framing-error reporting.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OS       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       o_rx_done,
  output logic [7:0] o_data,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned MAJ_LO = OS / 2 - 1;
  localparam int unsigned MAJ_HI = OS / 2 + 1;
  localparam int unsigned SW     = $clog2(OS);
  localparam int unsigned BW     = $clog2(DATA_BITS);
  localparam logic [SW:0]   T_LO    = (SW + 1)'(MAJ_LO);
  localparam logic [SW:0]   T_MID   = (SW + 1)'(OS / 2);
  localparam logic [SW:0]   T_HI    = (SW + 1)'(MAJ_HI);
  localparam logic [SW-1:0] S_LAST  = SW'(OS - 1);
  localparam logic [BW-1:0] BI_LAST = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic [7:0]           data_q, data_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 restart, os_tick;
  logic [SW:0]          tick_idx;
  logic                 bit_end, vote_valid, vote;

  uart_os_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OS       (OS)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .os_tick (os_tick)
  );

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    restart    = 1'b0;
    tick_idx   = {1'b0, s_cnt_q} + 1'b1;
    bit_end    = (s_cnt_q == S_LAST);
    vote_valid = 1'b0;
    vote       = rx_s_q;
    // Tick k lands k*DIV clocks into the bit; the vote resolves as soon as
    // two of the three mid-bit samples agree, so it is decided exactly once.
    if (tick_idx == T_MID && samp_q[0] == rx_s_q) begin
      vote_valid = 1'b1;
    end else if (tick_idx == T_HI && samp_q[0] != samp_q[1]) begin
      vote_valid = 1'b1;
      vote       = maj3(samp_q[0], samp_q[1], rx_s_q);
    end

    if (state_q == IDLE) begin
      if (rx_prev_q && !rx_s_q) begin
        state_d = START;
        s_cnt_d = '0;
        restart = 1'b1;
      end
    end else if (os_tick) begin
      s_cnt_d = bit_end ? '0 : s_cnt_q + 1'b1;
      if (tick_idx == T_LO)  samp_d[0] = rx_s_q;
      if (tick_idx == T_MID) samp_d[1] = rx_s_q;
      case (state_q)
        START: begin
          if (vote_valid && vote) begin
            state_d = IDLE;
          end else if (bit_end) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (vote_valid) shift_d[bit_idx_q] = vote;
          if (bit_end) begin
            if (bit_idx_q == BI_LAST) state_d = STOP;
            else                      bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        STOP: begin
          if (vote_valid) begin
            if (vote) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      s_cnt_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      s_cnt_q   <= s_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_rx_done   = done_q;
  assign o_data      = data_q;
  assign o_frame_err = err_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboarded bench for uart_rx_os: 1.6 MHz clock, 10 kbaud, 16x oversample (160 clk per bit).
module tb_uart_rx_os;

  localparam int BT = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       o_rx_done, o_frame_err, o_busy;
  logic [7:0] o_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  logic [7:0] snap_data;
  logic       snap_busy, snap_done, snap_err;

  uart_rx_os #(
    .CLK_FREQ (1_600_000),
    .BAUD     (10_000),
    .OS       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .o_rx_done   (o_rx_done),
    .o_data      (o_data),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (o_rx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got data=%h, expected no pulse", o_data);
      end else begin
        e = exp_q.pop_front();
        if (o_data !== e) begin
          bad++;
          $display("FAIL rx_byte: got %h, expected %h", o_data, e);
        end
      end
    end
    if (o_frame_err) err_cnt++;
    if (o_rx_done && o_frame_err) begin
      total++;
      bad++;
      $display("FAIL done_err_overlap: got both high, expected at most one");
    end
  end

  // Drives one 10-bit frame, one clk per iteration, starting on a negedge.
  task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_v,
                            input int spike_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    start_cyc = cyc;
    for (int k = 0; k < 10 * bt; k++) begin
      if (k == rst_at + 1) begin
        snap_data = o_data;
        snap_busy = o_busy;
        snap_done = o_rx_done;
        snap_err  = o_frame_err;
      end
      rx  = fr[k / bt];
      if (k == spike_at) rx = 1'b0;
      rst = (k == rst_at);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    total += 4;
    if (o_rx_done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b, expected 0", o_rx_done); end
    if (o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b, expected 0", o_frame_err); end
    if (o_busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
    if (o_data !== 8'h00)     begin bad++; $display("FAIL reset_data: got %h, expected 00", o_data); end
    rst = 1'b0;
    idle(2 * BT);
  endtask

  task automatic test_single;
    int d0, e0, lat;
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back(8'h02);
    send_frame(8'h02, BT, 1'b1, -1, -1);
    idle(BT);
    lat = last_done_cyc - start_cyc;
    total += 4;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_count: got %0d pulses, expected 1", done_cnt - d0); end
    // 9.5 bits to the stop-bit centre, plus sync/edge-detect latency.
    if (lat < 1510 || lat > 1530) begin bad++; $display("FAIL single_latency: got %0d clk, expected 1510..1530", lat); end
    if (err_cnt != e0) begin bad++; $display("FAIL single_err: got %0d errors, expected 0", err_cnt - e0); end
    if (o_data !== 8'h02) begin bad++; $display("FAIL single_data: got %h, expected 02", o_data); end
    last_good = 8'h02;
  endtask

  task automatic test_back_to_back;
    int rates[3] = '{160, 155, 165};
    logic [7:0] bytes[3] = '{8'h40, 8'h41, 8'h05};
    int d0, e0;
    foreach (rates[r]) begin
      d0 = done_cnt;
      e0 = err_cnt;
      foreach (bytes[i]) exp_q.push_back(bytes[i]);
      foreach (bytes[i]) send_frame(bytes[i], rates[r], 1'b1, -1, -1);
      idle(2 * BT);
      total += 2;
      if (done_cnt - d0 != 3) begin bad++; $display("FAIL b2b_count bt=%0d: got %0d pulses, expected 3", rates[r], done_cnt - d0); end
      if (err_cnt != e0) begin bad++; $display("FAIL b2b_err bt=%0d: got %0d errors, expected 0", rates[r], err_cnt - e0); end
    end
    last_good = 8'h05;
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 50) rx = 1'b1;
      if (i == 20) begin
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_on: got %b, expected 1", o_busy); end
      end
      if (i == 90) begin
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_off: got %b, expected 0", o_busy); end
      end
    end
    idle(2 * BT);
    total += 2;
    if (done_cnt != d0) begin bad++; $display("FAIL glitch_done: got %0d pulses, expected 0", done_cnt - d0); end
    if (err_cnt != e0) begin bad++; $display("FAIL glitch_err: got %0d errors, expected 0", err_cnt - e0); end
  endtask

  task automatic test_frame_err;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'hA5, BT, 1'b0, -1, -1);
    idle(2 * BT);
    total += 3;
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL ferr_count: got %0d errors, expected 1", err_cnt - e0); end
    if (done_cnt != d0) begin bad++; $display("FAIL ferr_done: got %0d pulses, expected 0", done_cnt - d0); end
    if (o_data !== last_good) begin bad++; $display("FAIL ferr_data: got %h, expected %h", o_data, last_good); end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, BT, 1'b1, -1, -1);
    idle(BT);
    total += 2;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL ferr_next_count: got %0d pulses, expected 1", done_cnt - d0); end
    if (o_data !== 8'h3C) begin bad++; $display("FAIL ferr_next_data: got %h, expected 3c", o_data); end
    last_good = 8'h3C;
  endtask

  task automatic test_break;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (30 * BT) @(negedge clk);
    total += 3;
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL break_err: got %0d errors, expected 1", err_cnt - e0); end
    if (done_cnt != d0) begin bad++; $display("FAIL break_done: got %0d pulses, expected 0", done_cnt - d0); end
    if (o_busy !== 1'b0) begin bad++; $display("FAIL break_busy: got %b, expected 0", o_busy); end
    idle(2 * BT);
  endtask

  task automatic test_spike;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(8'hFF);
    // Frame clk 720 is the centre of data bit 3.
    send_frame(8'hFF, BT, 1'b1, 720, -1);
    idle(BT);
    total += 2;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL spike_count: got %0d pulses, expected 1", done_cnt - d0); end
    if (o_data !== 8'hFF) begin bad++; $display("FAIL spike_data: got %h, expected ff", o_data); end
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    // Reset lands mid data bit 4; bits 4..7 of F0 are high so no stray start edge follows.
    send_frame(8'hF0, BT, 1'b1, -1, 880);
    idle(BT);
    total += 6;
    if (snap_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h, expected 00", snap_data); end
    if (snap_busy !== 1'b0)  begin bad++; $display("FAIL rstmid_busy: got %b, expected 0", snap_busy); end
    if (snap_done !== 1'b0)  begin bad++; $display("FAIL rstmid_done: got %b, expected 0", snap_done); end
    if (snap_err !== 1'b0)   begin bad++; $display("FAIL rstmid_err: got %b, expected 0", snap_err); end
    if (done_cnt != d0) begin bad++; $display("FAIL rstmid_pulse: got %0d pulses, expected 0", done_cnt - d0); end
    if (err_cnt != e0)  begin bad++; $display("FAIL rstmid_ferr: got %0d errors, expected 0", err_cnt - e0); end
    exp_q.push_back(8'h01);
    send_frame(8'h01, BT, 1'b1, -1, -1);
    idle(BT);
    total += 2;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL rstmid_next_count: got %0d pulses, expected 1", done_cnt - d0); end
    if (o_data !== 8'h01) begin bad++; $display("FAIL rstmid_next_data: got %h, expected 01", o_data); end
  endtask

  initial begin
    last_good = 8'h00;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_break;
    test_spike;
    test_reset_mid;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending bytes, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
